// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // 100 MHz system clock, 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/uart_receiver_synchronizer.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running level path.
// Ports: clk, rst (sync, active-high, loads RESET_VALUE), d (async in), q (synchronized out).
module synchronizer #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, byte and framing-error pulses.
// Latency: axiov / framing_error one cycle after the stop-bit sample.
// Backpressure: none; axiov is a single-cycle pulse, axiod holds until the next byte.
// Ports: clk, rst (sync, active-high), uart_rx (async line, idle high),
//        axiov / axiod (byte pulse and data), framing_error (pulse), busy (state != IDLE).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       axiov,
  output logic [7:0] axiod,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic           rx_s;
  uart_rx_state_t state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift_reg;
  // settle fills with ones once the synchronizer holds real line samples;
  // armed then requires a high line before the first start bit, so a reset
  // released while the line sits low mid-frame does not look like a start.
  logic [1:0]     settle;
  logic           armed;

  synchronizer #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (uart_rx),
    .q  (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      axiov         <= 1'b0;
      axiod         <= 8'h00;
      framing_error <= 1'b0;
      settle        <= 2'b00;
      armed         <= 1'b0;
    end else begin
      axiov         <= 1'b0;
      framing_error <= 1'b0;
      settle        <= {settle[0], 1'b1};
      if (settle[1] && rx_s) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end

        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= FULL_LOAD;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;  // glitch shorter than half a bit
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            cnt       <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              axiov <= 1'b1;
              axiod <= shift_reg;
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WAIT_IDLE: begin
          // A held-low break must not re-trigger; wait for the line to recover.
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int C = 16;
  // Line driven low at a negedge: 2 synchronizer edges, then the IDLE
  // detection edge, then C/2 + 9*C cycles to the stop sample edge, after
  // which axiov is visible at the following negedge.
  localparam int EXP_LAT = 3 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       axiov;
  logic [7:0] axiod;
  logic       framing_error;
  logic       busy;

  uart_receiver #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .axiov        (axiov),
    .axiod        (axiod),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vld_cnt = 0;
  int          fe_cnt = 0;
  int          both_cnt = 0;
  int unsigned last_vld_cyc = 0;

  always @(negedge clk) begin
    if (axiov) begin
      vld_cnt = vld_cnt + 1;
      last_vld_cyc = cyc;
    end
    if (framing_error) fe_cnt = fe_cnt + 1;
    if (axiov && framing_error) both_cnt = both_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int period, input logic stop_val,
                            output int unsigned start_cyc);
    uart_rx   = 1'b0;
    start_cyc = cyc;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (period) @(negedge clk);
    end
    uart_rx = stop_val;
    repeat (period) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    int         period;
    logic       stop_val;
    int         gap_bits;
    int         exp_vld;
    int         exp_fe;
    logic [7:0] exp_dat;
    logic       chk_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          v0, f0;
    int unsigned st;

    vecs[0] = '{8'hA5, 16, 1'b1, 2, 1, 0, 8'hA5, 1'b1};
    vecs[1] = '{8'h00, 16, 1'b1, 0, 1, 0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 16, 1'b1, 0, 1, 0, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 16, 1'b1, 2, 1, 0, 8'h3C, 1'b0};
    vecs[4] = '{8'hC3, 15, 1'b1, 2, 1, 0, 8'hC3, 1'b0};
    vecs[5] = '{8'hC3, 17, 1'b1, 2, 1, 0, 8'hC3, 1'b0};

    rst     = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("reset_axiov", axiov, 0);
    check("reset_framing_error", framing_error, 0);
    check("reset_axiod", axiod, 8'h00);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (4 * C) @(negedge clk);

    // Table-driven frames: clean, back-to-back, and off-rate bit periods.
    for (int i = 0; i < 6; i++) begin
      v0 = vld_cnt;
      f0 = fe_cnt;
      send_frame(vecs[i].data, vecs[i].period, vecs[i].stop_val, st);
      repeat (vecs[i].gap_bits * vecs[i].period) @(negedge clk);
      check($sformatf("vec%0d_axiov_count", i), vld_cnt - v0, vecs[i].exp_vld);
      check($sformatf("vec%0d_fe_count", i), fe_cnt - f0, vecs[i].exp_fe);
      check($sformatf("vec%0d_axiod", i), axiod, vecs[i].exp_dat);
      if (vecs[i].chk_lat) check($sformatf("vec%0d_latency", i), last_vld_cyc - st, EXP_LAT);
      if (vecs[i].gap_bits > 0) check($sformatf("vec%0d_busy_idle", i), busy, 0);
    end

    // Short low glitch on an idle line.
    v0 = vld_cnt;
    f0 = fe_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_high", busy, 1);
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_low", busy, 0);
    check("glitch_axiov", vld_cnt - v0, 0);
    check("glitch_fe", fe_cnt - f0, 0);

    // Bad stop bit followed by a long break, then recovery.
    v0 = vld_cnt;
    f0 = fe_cnt;
    send_frame(8'h55, C, 1'b0, st);
    repeat (40 * C) @(negedge clk);
    check("break_fe_count", fe_cnt - f0, 1);
    check("break_axiov", vld_cnt - v0, 0);
    check("break_axiod_kept", axiod, 8'hC3);
    check("break_wait_idle_busy", busy, 1);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    check("break_release_busy", busy, 0);
    repeat (2 * C) @(negedge clk);
    send_frame(8'h12, C, 1'b1, st);
    repeat (2 * C) @(negedge clk);
    check("after_break_axiov", vld_cnt - v0, 1);
    check("after_break_axiod", axiod, 8'h12);
    check("after_break_fe_count", fe_cnt - f0, 1);

    // Reset during data bit 4 (line low) of 0x81.
    v0 = vld_cnt;
    f0 = fe_cnt;
    fork
      send_frame(8'h81, C, 1'b1, st);
      begin
        repeat (C + 4 * C + 5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (2 * C) @(negedge clk);
    check("rst_mid_axiov", vld_cnt - v0, 0);
    check("rst_mid_fe", fe_cnt - f0, 0);
    check("rst_mid_axiod_cleared", axiod, 8'h00);
    check("rst_mid_busy", busy, 0);
    send_frame(8'h7E, C, 1'b1, st);
    repeat (2 * C) @(negedge clk);
    check("after_rst_axiov", vld_cnt - v0, 1);
    check("after_rst_axiod", axiod, 8'h7E);

    check("never_both_pulses", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 CLKS_PER_BIT, default 868, sys_clk cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 axiov  output  1  one-cycle pulse; axiod holds a valid received byte.
REQ-006 axiod  output  8  received byte; holds its value until the next axiov.
REQ-007 framing_error  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 uart_rx shall pass through a 2-flop synchronizer; all logic uses only the synchronized value rx_s.
REQ-010 The block shall use the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-011 IDLE: on the first cycle with rx_s = 0 (t0), go to START and load the bit counter with CLKS_PER_BIT/2 - 1 (integer division).
REQ-012 START: when the counter reaches 0, sample rx_s; if 0, go to DATA with the counter at CLKS_PER_BIT-1 and the bit index at 0; if 1 (glitch), return to IDLE with no output pulse.
REQ-013 DATA: each time the counter reaches 0, shift rx_s into the shift register, LSB first, and reload the counter; after bit index 7, go to STOP.
REQ-014 STOP: when the counter reaches 0, sample rx_s. If 1, pulse axiov on the next cycle, update axiod, and go to IDLE. If 0, pulse framing_error on the next cycle, leave axiod unchanged, and go to WAIT_IDLE.
REQ-015 WAIT_IDLE: stay in this state until rx_s = 1, then go to IDLE, so that a held-low break produces exactly one framing_error.
REQ-016 Sample instants shall fall at t0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT, with k=0 for the start bit, k=1..8 for data and k=9 for the stop bit.
REQ-017 Latency from the stop-bit sample to axiov shall be exactly 1 cycle; axiov and framing_error shall never be high in the same cycle.
REQ-018 Back-to-back frames shall be received with zero idle bits: IDLE is re-entered in time to detect a start bit that begins half a bit after the stop-bit sample.
REQ-019 The counter width shall be $clog2(CLKS_PER_BIT); the bit index shall be 3 bits; no arithmetic wraps beyond these widths.

Reset
REQ-020 Reset shall set: state IDLE, axiov 0, framing_error 0, axiod 8'h00, busy 0, counters 0, and both synchronizer flops 1.
REQ-021 Reset asserted mid-frame shall abort the frame with no pulse on either output; after release the block re-arms only on a new falling edge of rx_s.

Structure
REQ-022 Package uart_pkg shall hold the state enum typedef (uart_rx_state_t) and the constant DEFAULT_CLKS_PER_BIT = 868.
REQ-023 The 2-flop synchronizer shall be a separate sub-module named synchronizer, with a reset value parameter set to 1 here.
REQ-024 Expected implementation size: 120-200 lines of RTL.

Verification (bench uses CLKS_PER_BIT = 16)
REQ-025 Frame 0xA5 with clean 16-cycle bits -> exactly one axiov, axiod = 8'hA5, framing_error stays 0, axiov 1 cycle after the stop-bit sample.
REQ-026 Three back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three axiov pulses carrying those values in order.
REQ-027 Low glitch of 5 cycles on an idle line -> no axiov, no framing_error, busy returns to 0 within 8 cycles.
REQ-028 Frame 0x55 with the stop bit driven 0, then the line held low 40 bit times -> exactly one framing_error, axiod keeps its previous value, the block stays in WAIT_IDLE until the line goes high, then 0x12 is received correctly.
REQ-029 rst pulsed during data bit 4 of frame 0x81 -> no pulse on either output; the next frame 0x7E yields axiod = 8'h7E.
REQ-030 Frame 0xC3 with bit period 15 and then 17 cycles (about ±6%) -> axiod = 8'hC3 in both cases.
